// File: rtl/spikegen.sv
// spikegen: rate-to-spike encoder.
// Each slow_clk period, takes rate_in and emits that many fixed-width pulses on
// fast_clk. The pulses are spread evenly across the last measured period
// using a centred DDA.
// Ports:
//   fast_clk    - sole clock, rising edge
//   reset       - asynchronous, active-low
//   slow_clk    - period reference, asynchronous to fast_clk
//   rate_in     - spikes requested for the coming period, sampled on tick
//   spike       - registered spike train
//   emitted_cnt - spikes started in the last completed period
//   period_len  - last measured period in fast_clk cycles
//   drop_flag   - last completed period lost or clamped spikes
module spikegen #(
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_W   = 1,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PER_W   = 24,
  parameter int unsigned PEND_W  = 16
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic [CNT_W-1:0] rate_in,
  output logic             spike,
  output logic [CNT_W-1:0] emitted_cnt,
  output logic [PER_W-1:0] period_len,
  output logic             drop_flag
);

  localparam int unsigned MW = (CNT_W > PER_W) ? CNT_W : PER_W;
  localparam int unsigned HW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned SW = $clog2(HW + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic              sync1, sync2, sync3;
  logic              tick;
  logic [PER_W-1:0]  pcnt;
  logic              seen_tick, period_valid;
  logic [PER_W-1:0]  n_rate;
  logic              clamp;
  logic [PER_W:0]    acc;
  logic [PEND_W-1:0] pending;
  logic              ovf;
  logic [CNT_W-1:0]  ecnt;
  state_t            state;
  logic [SW-1:0]     scnt;

  logic [PER_W-1:0]  p_meas, n_new, dda_p, dda_n;
  logic [PER_W:0]    dda_base, dda_sum, acc_next;
  logic              gen_en, clamp_new, req, free, accept;

  assign tick = sync2 & ~sync3;

  always_comb begin
    p_meas    = (&pcnt) ? pcnt : pcnt + PER_W'(1);
    // Generation starts on the tick that makes the period measurement valid.
    gen_en    = tick ? (seen_tick | period_valid) : period_valid;
    clamp_new = MW'(rate_in) > MW'(p_meas);
    n_new     = '0;
    if (gen_en) n_new = clamp_new ? p_meas : PER_W'(rate_in);
    dda_p     = tick ? p_meas : period_len;
    dda_n     = tick ? n_new : n_rate;
    dda_base  = tick ? {1'b0, p_meas >> 1} : acc;
    dda_sum   = dda_base + {1'b0, dda_n};
    req       = gen_en && (dda_sum >= {1'b0, dda_p});
    acc_next  = req ? dda_sum - {1'b0, dda_p} : dda_sum;
    free      = (state == IDLE) || ((state == LOW) && (scnt == SW'(GAP_W - 1)));
    // Backlog of the ending period is discarded on tick, so only a fresh
    // request can start a pulse in the tick cycle.
    accept    = free && (req || (!tick && (pending != '0)));
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      pcnt         <= '0;
      period_len   <= '0;
      seen_tick    <= 1'b0;
      period_valid <= 1'b0;
      n_rate       <= '0;
      clamp        <= 1'b0;
      acc          <= '0;
      pending      <= '0;
      ovf          <= 1'b0;
      ecnt         <= '0;
      emitted_cnt  <= '0;
      drop_flag    <= 1'b0;
    end else begin
      sync1 <= slow_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      acc   <= acc_next;
      if (tick) begin
        pcnt        <= '0;
        period_len  <= p_meas;
        seen_tick   <= 1'b1;
        if (seen_tick) period_valid <= 1'b1;
        n_rate      <= n_new;
        clamp       <= gen_en & clamp_new;
        drop_flag   <= clamp | ovf | (pending != '0);
        emitted_cnt <= ecnt;
        ecnt        <= CNT_W'(accept);
        ovf         <= 1'b0;
        // A tick-cycle request that finds the shaper busy belongs to the new
        // period and is kept as its first pending spike.
        pending     <= PEND_W'(req && !accept);
      end else begin
        pcnt <= (&pcnt) ? pcnt : pcnt + PER_W'(1);
        ecnt <= ecnt + CNT_W'(accept);
        if (req && !accept) begin
          if (&pending) ovf <= 1'b1;
          else          pending <= pending + PEND_W'(1);
        end else if (!req && accept) begin
          pending <= pending - PEND_W'(1);
        end
      end
    end
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      scnt  <= '0;
      spike <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= HIGH;
            scnt  <= '0;
            spike <= 1'b1;
          end
        end
        HIGH: begin
          if (scnt == SW'(PULSE_W - 1)) begin
            state <= LOW;
            scnt  <= '0;
            spike <= 1'b0;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        LOW: begin
          if (scnt == SW'(GAP_W - 1)) begin
            scnt <= '0;
            if (accept) begin
              state <= HIGH;
              spike <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        default: begin
          state <= IDLE;
          scnt  <= '0;
          spike <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spikegen.sv
// Directed bench for spikegen. slow_clk periods are generated as whole
// numbers of fast_clk cycles. Spike rise positions are recorded relative to
// the tick cycle (cycle 0). Outputs are snapshotted just after the tick edge.
module tb_spikegen;

  logic        fast_clk = 1'b0;
  logic        reset    = 1'b0;
  logic        slow_clk = 1'b0;
  logic [31:0] rate_in  = '0;
  logic        spike;
  logic [31:0] emitted_cnt;
  logic [23:0] period_len;
  logic        drop_flag;

  spikegen #(
    .PULSE_W(1),
    .GAP_W  (1),
    .CNT_W  (32),
    .PER_W  (24),
    .PEND_W (16)
  ) dut (
    .fast_clk   (fast_clk),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .rate_in    (rate_in),
    .spike      (spike),
    .emitted_cnt(emitted_cnt),
    .period_len (period_len),
    .drop_flag  (drop_flag)
  );

  always #5 fast_clk = ~fast_clk;

  int     checks = 0;
  int     errors = 0;
  int     rises[$];
  int     nhigh;
  logic   prev_spike = 1'b0;
  longint snap_emit, snap_plen, snap_drop;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One slow_clk period of len fast cycles. Entered just after a posedge.
  // The tick falls in the cycle ending at the third edge, so sample i
  // observes cycle i-1 relative to the tick.
  task automatic period(input int len);
    rises.delete();
    nhigh = 0;
    slow_clk = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge fast_clk); #1;
      if (i == len / 2) slow_clk = 1'b0;
      if (i == 2) begin
        snap_emit = emitted_cnt;
        snap_plen = period_len;
        snap_drop = drop_flag;
      end
      if (spike && !prev_spike && i >= 1) rises.push_back(i - 1);
      if (spike) nhigh++;
      prev_spike = spike;
    end
  endtask

  task automatic check_rises(input string tag, input int first, input int step, input int n);
    check({tag, "_count"}, rises.size(), n);
    for (int k = 0; k < n; k++)
      check($sformatf("%s_rise%0d", tag, k), (k < rises.size()) ? rises[k] : -1, first + k * step);
  endtask

  task automatic check_snap(input string tag, input longint e, input longint p, input longint d);
    check({tag, "_emitted"}, snap_emit, e);
    check({tag, "_period"},  snap_plen, p);
    check({tag, "_drop"},    snap_drop, d);
  endtask

  initial begin
    repeat (3) @(posedge fast_clk);
    #1;
    check("rst_spike",   spike, 0);
    check("rst_emitted", emitted_cnt, 0);
    check("rst_period",  period_len, 0);
    check("rst_drop",    drop_flag, 0);
    reset = 1'b1;
    @(posedge fast_clk); #1;

    // Two ticks before generation; rate 4 over 100 cycles.
    rate_in = 4;
    period(100);
    check("first_tick_nospike", nhigh, 0);
    period(100);
    check_snap("valid_tick", 0, 100, 0);
    check_rises("even1", 13, 25, 4);
    period(100);
    check_snap("even_end", 4, 100, 0);
    check_rises("even2", 13, 25, 4);

    // Zero rate.
    rate_in = 0;
    period(100);
    check("zero_nohigh", nhigh, 0);

    // Shaper limit.
    rate_in = 80;
    period(100);
    check_snap("zero_end", 0, 100, 0);
    check_rises("shaper", 1, 2, 49);

    // Clamp, then recovery.
    rate_in = 150;
    period(100);
    check_snap("shaper_end", 50, 100, 1);
    check_rises("clamp", 1, 2, 49);
    rate_in = 10;
    period(100);
    check_snap("clamp_end", 50, 100, 1);
    check_rises("rate10", 5, 10, 10);

    // Period change 100 -> 200.
    rate_in = 4;
    period(100);
    check_snap("rate10_end", 10, 100, 0);
    period(200);
    check_snap("pre_change", 4, 100, 0);
    check_rises("stretched", 13, 25, 8);
    period(200);
    check_snap("change_end", 8, 200, 0);
    check_rises("p200", 25, 50, 4);
    period(200);
    check_snap("p200_end", 4, 200, 0);

    // Reset in the middle of a HIGH pulse.
    slow_clk = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge fast_clk); #1;
      if (i == 10) slow_clk = 1'b1;
      if (spike) break;
    end
    check("mid_pulse_high", spike, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_spike",   spike, 0);
    check("mid_rst_emitted", emitted_cnt, 0);
    check("mid_rst_period",  period_len, 0);
    check("mid_rst_drop",    drop_flag, 0);
    slow_clk = 1'b0;
    prev_spike = 1'b0;
    repeat (3) @(posedge fast_clk);
    #1;
    reset = 1'b1;
    @(posedge fast_clk); #1;
    period(100);
    check("post_rst_first_nospike", nhigh, 0);
    period(100);
    check_snap("post_rst_valid", 0, 100, 0);
    check_rises("post_rst", 13, 25, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
